// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default parameters for the fifo write-port arbiter and its picker.
package fifo_write_arbiter_pkg;

   localparam int DEF_N         = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 16;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // Ceiling log2 clamped to 1 so an index or counter never collapses to zero width.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector by the pointer,
// find the first set bit, then rotate the winner back to its absolute index.
module fifo_write_arbiter_rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int ID_BITS = clog2_min1(N)
) (
   input  logic [N-1:0]       i_req,
   input  logic [ID_BITS-1:0] i_ptr,
   output logic [N-1:0]       o_pick,
   output logic [ID_BITS-1:0] o_pick_id
);

   logic [N-1:0]       w_rot;
   logic [ID_BITS-1:0] w_first_id;
   logic [ID_BITS-1:0] w_rot_idx;
   logic               w_any;

   // w_rot[i] is the requester i places above the pointer.
   always_comb begin
      w_rot     = '0;
      w_rot_idx = '0;
      for (int i = 0; i < N; i++) begin
         w_rot_idx = ID_BITS'((i + int'(i_ptr)) % N);
         w_rot[i]  = i_req[w_rot_idx];
      end
   end

   always_comb begin
      w_first_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_first_id = ID_BITS'(i);
         end
      end
   end

   assign w_any     = |w_rot;
   assign o_pick_id = ID_BITS'((int'(w_first_id) + int'(i_ptr)) % N);

   always_comb begin
      o_pick = '0;
      if (w_any) begin
         o_pick[o_pick_id] = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one fifo write port among N requesters;
// writes are gated by the fifo's space_available so the fifo never sees an overflow write.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter  int N         = DEF_N,
   parameter  int WIDTH     = DEF_WIDTH,
   parameter  int MAX_BURST = DEF_MAX_BURST,
   parameter  int ID_BITS   = clog2_min1(N),
   localparam int CNT_BITS  = clog2_min1(MAX_BURST)
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [N-1:0]        i_req,
   input  logic [N-1:0]        i_last,
   input  logic [N*WIDTH-1:0]  i_data,
   output logic [N-1:0]        o_ack,
   output logic [N-1:0]        o_grant,
   output logic [ID_BITS-1:0]  o_owner,
   input  logic                i_fifo_space_available,
   output logic [WIDTH-1:0]    o_fifo_write_data,
   output logic                o_fifo_write_strobe,
   output logic                o_forced_release,
   output arb_state_t          o_dbg_state,
   output logic [ID_BITS-1:0]  o_dbg_rr_ptr,
   output logic [CNT_BITS-1:0] o_dbg_count
);

   // Handshake: a word on lane i moves when req[i] and ack[i] are both high in the same
   // cycle; ack is combinational from req[owner] and space_available, and the requester
   // holds data/last stable while req is high and ack is low.

   localparam logic [CNT_BITS-1:0] LP_CNT_LAST = CNT_BITS'(MAX_BURST - 1);
   localparam logic [ID_BITS-1:0]  LP_ID_LAST  = ID_BITS'(N - 1);

   arb_state_t          r_state, w_state_nx;
   logic [N-1:0]        r_grant, w_grant_nx;
   logic [ID_BITS-1:0]  r_owner, w_owner_nx;
   logic [ID_BITS-1:0]  r_rr_ptr, w_rr_ptr_nx;
   logic [CNT_BITS-1:0] r_count, w_count_nx;
   logic                r_forced_release, w_forced_nx;

   logic [N-1:0]        w_pick;
   logic [ID_BITS-1:0]  w_pick_id;
   logic [N-1:0]        w_owner_oh;
   logic [ID_BITS-1:0]  w_owner_inc;
   logic                w_req_own;
   logic                w_last_own;
   logic                w_xfer;
   logic                w_release;

   fifo_write_arbiter_rr_pick #(
      .N       (N),
      .ID_BITS (ID_BITS)
   ) u_rr_pick (
      .i_req     (i_req),
      .i_ptr     (r_rr_ptr),
      .o_pick    (w_pick),
      .o_pick_id (w_pick_id)
   );

   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < N; i++) begin
         w_owner_oh[i] = (r_owner == ID_BITS'(i));
      end
   end

   assign w_req_own   = |(i_req & w_owner_oh);
   assign w_last_own  = |(i_last & w_owner_oh);
   assign w_xfer      = (r_state == ARB_BURST) && w_req_own && i_fifo_space_available;
   assign w_owner_inc = (r_owner == LP_ID_LAST) ? '0 : r_owner + ID_BITS'(1);

   always_comb begin
      w_state_nx  = r_state;
      w_grant_nx  = r_grant;
      w_owner_nx  = r_owner;
      w_rr_ptr_nx = r_rr_ptr;
      w_count_nx  = r_count;
      w_forced_nx = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|i_req) begin
               w_state_nx = ARB_BURST;
               w_grant_nx = w_pick;
               w_owner_nx = w_pick_id;
               w_count_nx = '0;
            end
         end
         ARB_BURST: begin
            // A dropped request aborts the packet; a low space_available merely stalls.
            if (!w_req_own) begin
               w_release = 1'b1;
            end else if (w_xfer) begin
               if (w_last_own) begin
                  w_release = 1'b1;
               end else if (r_count == LP_CNT_LAST) begin
                  w_release   = 1'b1;
                  w_forced_nx = 1'b1;
               end else begin
                  w_count_nx = r_count + CNT_BITS'(1);
               end
            end
         end
         default: w_state_nx = ARB_IDLE;
      endcase
      if (w_release) begin
         w_state_nx  = ARB_IDLE;
         w_grant_nx  = '0;
         w_rr_ptr_nx = w_owner_inc;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state          <= ARB_IDLE;
         r_grant          <= '0;
         r_owner          <= '0;
         r_rr_ptr         <= '0;
         r_count          <= '0;
         r_forced_release <= 1'b0;
      end else begin
         r_state          <= w_state_nx;
         r_grant          <= w_grant_nx;
         r_owner          <= w_owner_nx;
         r_rr_ptr         <= w_rr_ptr_nx;
         r_count          <= w_count_nx;
         r_forced_release <= w_forced_nx;
      end
   end

   always_comb begin
      o_fifo_write_data = i_data[WIDTH-1:0];
      for (int i = 1; i < N; i++) begin
         if (r_owner == ID_BITS'(i)) begin
            o_fifo_write_data = i_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign o_ack               = w_xfer ? w_owner_oh : '0;
   assign o_fifo_write_strobe = w_xfer;
   assign o_grant             = r_grant;
   assign o_owner             = r_owner;
   assign o_forced_release    = r_forced_release;
   assign o_dbg_state         = r_state;
   assign o_dbg_rr_ptr        = r_rr_ptr;
   assign o_dbg_count         = r_count;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed vector table, multi-cycle corner sequences,
// a fifo-space integration run and a randomized run against a behavioural model.
module tb_fifo_write_arbiter;
   import fifo_write_arbiter_pkg::*;

   localparam int N         = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;
   localparam int ID_BITS   = 2;
   localparam int CNT_BITS  = 2;

   logic               clk;
   logic               reset_n;
   logic [N-1:0]       req, last, ack, grant;
   logic [N*WIDTH-1:0] data;
   logic [ID_BITS-1:0] owner, dbg_ptr;
   logic               space, strobe, forced;
   logic [WIDTH-1:0]   wdata;
   arb_state_t         dbg_state;
   logic [CNT_BITS-1:0] dbg_count;

   int n_checks = 0;
   int n_errors = 0;

   fifo_write_arbiter #(
      .N         (N),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .i_clk                  (clk),
      .i_reset_n              (reset_n),
      .i_req                  (req),
      .i_last                 (last),
      .i_data                 (data),
      .o_ack                  (ack),
      .o_grant                (grant),
      .o_owner                (owner),
      .i_fifo_space_available (space),
      .o_fifo_write_data      (wdata),
      .o_fifo_write_strobe    (strobe),
      .o_forced_release       (forced),
      .o_dbg_state            (dbg_state),
      .o_dbg_rr_ptr           (dbg_ptr),
      .o_dbg_count            (dbg_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_edge();
      @(negedge clk);
   endtask

   // Called at a drive point; the pulse sits well clear of both clock edges.
   task automatic pulse_reset();
      req     = '0;
      last    = '0;
      data    = '0;
      space   = 1'b1;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic               rst;
      logic [N-1:0]       req;
      logic [N-1:0]       last;
      logic [N*WIDTH-1:0] data;
      logic               space;
      logic [N-1:0]       e_ack;
      logic               e_strobe;
      logic [WIDTH-1:0]   e_wdata;
      logic [N-1:0]       e_grant;
      logic [ID_BITS-1:0] e_owner;
      logic [ID_BITS-1:0] e_ptr;
      logic               e_forced;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] ls,
                               input logic [31:0] dt, input logic sp, input logic [3:0] ea,
                               input logic es, input logic [7:0] ew, input logic [3:0] eg,
                               input logic [1:0] eo, input logic [1:0] ep, input logic ef);
      vec_t v;
      v.rst = rst; v.req = rq; v.last = ls; v.data = dt; v.space = sp;
      v.e_ack = ea; v.e_strobe = es; v.e_wdata = ew; v.e_grant = eg;
      v.e_owner = eo; v.e_ptr = ep; v.e_forced = ef;
      return v;
   endfunction

   // ---------------- scoreboard / model state ----------------
   logic [15:0]  exp_q[$];
   logic [15:0]  exp_item;
   logic [N-1:0] prev_ack;
   logic [N-1:0] e_ack, e_grant;
   logic         e_strobe, exp_f;
   int           sent, stall, w1, n_forced, fifo_cnt;
   int           wcnt[N];
   bit           m_busy, m_forced;
   int           m_owner, m_ptr, m_words;

   initial begin
      reset_n = 1'b0;
      req = '0; last = '0; data = '0; space = 1'b1;

      // Reset state, checked while reset is held and before any clock edge.
      #3;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_ptr", 32'(dbg_ptr), 32'd0);
      chk("rst_count", 32'(dbg_count), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      chk("rst_forced", 32'(forced), 32'd0);
      chk("rst_strobe", 32'(strobe), 32'd0);
      drive_edge();
      reset_n = 1'b1;

      // Single requester 3-word packet, then four-way fairness with 1-word packets.
      //             rst  req      last     data          sp  ack      stb  wdata  grant    own  ptr  frc
      tbl.push_back(mk(1, 4'b0100, 4'b0000, 32'h00A1_0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A1_0000, 1, 4'b0100, 1, 8'hA1, 4'b0100, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A2_0000, 1, 4'b0100, 1, 8'hA2, 4'b0100, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h00A3_0000, 1, 4'b0100, 1, 8'hA3, 4'b0100, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 2, 3, 0));
      tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0001, 1, 8'h10, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0010, 1, 8'h11, 4'b0010, 1, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0000, 0, 8'h00, 4'b0000, 1, 2, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0100, 1, 8'h12, 4'b0100, 2, 2, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0000, 0, 8'h00, 4'b0000, 2, 3, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b1000, 1, 8'h13, 4'b1000, 3, 3, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0000, 0, 8'h00, 4'b0000, 3, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 4'b0001, 1, 8'h10, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 1, 0));

      foreach (tbl[i]) begin
         drive_edge();
         if (tbl[i].rst) pulse_reset();
         req   = tbl[i].req;
         last  = tbl[i].last;
         data  = tbl[i].data;
         space = tbl[i].space;
         sample_edge();
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
         chk($sformatf("vec%0d_strobe", i), 32'(strobe), 32'(tbl[i].e_strobe));
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
         chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].e_owner));
         chk($sformatf("vec%0d_ptr", i), 32'(dbg_ptr), 32'(tbl[i].e_ptr));
         chk($sformatf("vec%0d_forced", i), 32'(forced), 32'(tbl[i].e_forced));
         if (tbl[i].e_strobe) chk($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(tbl[i].e_wdata));
      end

      // Forced release: lane 1 streams 10 words without last, lane 3 has one word pending.
      drive_edge();
      pulse_reset();
      exp_q.delete();
      for (int w = 1; w <= 10; w++) begin
         if (w == 5) exp_q.push_back({8'd3, 8'h33});
         exp_q.push_back({8'd1, 8'(w)});
      end
      req = 4'b1010; last = 4'b1000;
      data[15:8] = 8'd1; data[31:24] = 8'h33;
      w1 = 1; exp_f = 1'b0; n_forced = 0; prev_ack = '0;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         if (cyc > 0) begin
            drive_edge();
            if (prev_ack[1]) begin
               w1++;
               if (w1 > 10) req[1] = 1'b0;
               else data[15:8] = 8'(w1);
            end
            if (prev_ack[3]) begin
               req[3] = 1'b0; last[3] = 1'b0;
            end
         end
         sample_edge();
         chk("frc_pulse", 32'(forced), 32'(exp_f));
         n_forced += int'(forced);
         exp_f = 1'b0;
         if (strobe) begin
            exp_item = exp_q.pop_front();
            chk("frc_order", {16'd0, 6'd0, owner, wdata}, {16'd0, exp_item});
            if (exp_item == {8'd1, 8'd4} || exp_item == {8'd1, 8'd8}) exp_f = 1'b1;
         end
         prev_ack = ack;
      end
      chk("frc_drain", 32'(exp_q.size()), 32'd0);
      drive_edge();
      sample_edge();
      chk("frc_tail", 32'(forced), 32'(exp_f));
      n_forced += int'(forced);
      chk("frc_pulses", 32'(n_forced), 32'd2);

      // Backpressure: space low for 5 cycles after two words of a 6-word packet.
      drive_edge();
      pulse_reset();
      req = 4'b0001; data[7:0] = 8'hB1;
      sent = 0; stall = 0; prev_ack = '0;
      for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
         if (cyc > 0) begin
            drive_edge();
            if (prev_ack[0]) begin
               sent++;
               if (sent == 6) req[0] = 1'b0;
               else begin
                  data[7:0] = 8'(8'hB1 + sent);
                  last[0]   = (sent == 5);
               end
            end
            if (sent == 2 && stall < 5) begin
               space = 1'b0; stall++;
            end else begin
               space = 1'b1;
            end
         end
         sample_edge();
         if (!space) begin
            chk("bp_strobe", 32'(strobe), 32'd0);
            chk("bp_ack", 32'(ack), 32'd0);
            chk("bp_grant", 32'(grant), 32'd1);
            chk("bp_count", 32'(dbg_count), 32'd2);
         end
         if (strobe) chk("bp_data", 32'(wdata), 32'(8'(8'hB1 + sent)));
         prev_ack = ack;
      end
      chk("bp_stall", 32'(stall), 32'd5);
      chk("bp_words", 32'(sent), 32'd6);

      // Abort: requester 0 drops req mid-burst.
      drive_edge();
      pulse_reset();
      req = 4'b0001; data[7:0] = 8'hC1;
      sample_edge();
      chk("ab_idle_grant", 32'(grant), 32'd0);
      drive_edge();
      sample_edge();
      chk("ab_w1_strobe", 32'(strobe), 32'd1);
      chk("ab_w1_data", 32'(wdata), 32'hC1);
      drive_edge();
      data[7:0] = 8'hC2;
      sample_edge();
      chk("ab_w2_strobe", 32'(strobe), 32'd1);
      chk("ab_w2_data", 32'(wdata), 32'hC2);
      drive_edge();
      req = 4'b0000;
      sample_edge();
      chk("ab_drop_strobe", 32'(strobe), 32'd0);
      chk("ab_drop_ack", 32'(ack), 32'd0);
      chk("ab_drop_grant", 32'(grant), 32'd1);
      drive_edge();
      sample_edge();
      chk("ab_state", 32'(dbg_state), 32'(ARB_IDLE));
      chk("ab_grant", 32'(grant), 32'd0);
      chk("ab_ptr", 32'(dbg_ptr), 32'd1);

      // Asynchronous reset mid-burst, no clock edge in between.
      drive_edge();
      pulse_reset();
      req = 4'b0100; data[23:16] = 8'hD1;
      sample_edge();
      drive_edge();
      sample_edge();
      chk("ar_pre_strobe", 32'(strobe), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("ar_grant", 32'(grant), 32'd0);
      chk("ar_ack", 32'(ack), 32'd0);
      chk("ar_strobe", 32'(strobe), 32'd0);
      chk("ar_state", 32'(dbg_state), 32'(ARB_IDLE));
      chk("ar_owner", 32'(owner), 32'd0);
      #1;
      reset_n = 1'b1;
      drive_edge();
      req = '0;

      // Integration: NUM=8 fifo with no reads accepts 7 words; three lanes stream 4-word packets.
      drive_edge();
      pulse_reset();
      fifo_cnt = 0; prev_ack = '0;
      for (int i = 0; i < 3; i++) begin
         wcnt[i] = 0;
         data[i*WIDTH +: WIDTH] = 8'(i * 16);
      end
      req = 4'b0111;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc > 0) begin
            drive_edge();
            for (int i = 0; i < 3; i++) begin
               if (prev_ack[i]) begin
                  wcnt[i]++;
                  data[i*WIDTH +: WIDTH] = 8'(i * 16 + wcnt[i]);
                  last[i] = ((wcnt[i] % 4) == 3);
               end
            end
            space = (fifo_cnt < 7);
         end
         sample_edge();
         chk("int_werror", 32'(strobe & ~space), 32'd0);
         if (strobe) fifo_cnt++;
         prev_ack = ack;
      end
      chk("int_words", 32'(fifo_cnt), 32'd7);

      // Randomized run against the behavioural model.
      drive_edge();
      pulse_reset();
      m_busy = 0; m_forced = 0; m_owner = 0; m_ptr = 0; m_words = 0;
      prev_ack = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc > 0) drive_edge();
         for (int i = 0; i < N; i++) begin
            if (req[i] && prev_ack[i]) begin
               if ($urandom_range(0, 9) < 7) begin
                  data[i*WIDTH +: WIDTH] = 8'($urandom);
                  last[i] = ($urandom_range(0, 3) == 0);
               end else begin
                  req[i] = 1'b0; last[i] = 1'b0;
               end
            end else if (req[i]) begin
               if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
               req[i] = 1'b1;
               data[i*WIDTH +: WIDTH] = 8'($urandom);
               last[i] = ($urandom_range(0, 3) == 0);
            end
         end
         space = ($urandom_range(0, 3) != 0);
         sample_edge();

         e_strobe = m_busy && req[m_owner] && space;
         e_grant  = m_busy ? N'(1 << m_owner) : '0;
         e_ack    = e_strobe ? N'(1 << m_owner) : '0;
         chk("rnd_strobe", 32'(strobe), 32'(e_strobe));
         chk("rnd_ack", 32'(ack), 32'(e_ack));
         chk("rnd_grant", 32'(grant), 32'(e_grant));
         chk("rnd_owner", 32'(owner), 32'(m_owner));
         chk("rnd_forced", 32'(forced), 32'(m_forced));
         if (e_strobe) chk("rnd_wdata", 32'(wdata), 32'(data[m_owner*WIDTH +: WIDTH]));

         // Model: pick the first requester at or above the pointer; one packet per grant.
         m_forced = 1'b0;
         if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               if (!m_busy && req[(m_ptr + k) % N]) begin
                  m_busy  = 1'b1;
                  m_owner = (m_ptr + k) % N;
                  m_words = 0;
               end
            end
         end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
         end else if (space) begin
            m_words++;
            if (last[m_owner] || m_words == MAX_BURST) begin
               m_forced = !last[m_owner];
               m_busy   = 1'b0;
               m_ptr    = (m_owner + 1) % N;
            end
         end
         prev_ack = e_ack;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of a `fifo` instance between N independent requesters using round-robin, burst-granular arbitration. A grant is held for one packet, framed by a `last` flag or capped at MAX_BURST words, so no requester can starve the others. Writes are throttled by the fifo's `space_available`, so the arbiter never causes a `werror`. It sits between the capture/producer blocks and the shared output fifo.

## Interface
- N, 4: number of requesters (2..16).
- WIDTH, 8: data word width; matches the fifo WIDTH.
- MAX_BURST, 16: maximum words per grant before forced release (≥1).
- ID_BITS, `CLOG2(N)`: width of the owner index.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N  requester i has a word on its data lane.
- last  in  N  the current word of requester i ends its packet.
- data  in  N*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- ack  out  N  word on lane i accepted this cycle (combinational).
- grant  out  N  one-hot registered grant; zero when idle.
- owner  out  ID_BITS  index of the current or most recent owner.
- fifo_space_available  in  1  from the fifo's `space_available`.
- fifo_write_data  out  WIDTH  connect to the fifo's `write_data`.
- fifo_write_strobe  out  1  connect to the fifo's `write_strobe` (combinational).
- forced_release  out  1  one-cycle pulse when a burst is cut at MAX_BURST.

## Operation
- States:
  - IDLE: no grant.
  - BURST: `grant[owner]` = 1.
- IDLE:
  - If any `req` is set, pick the first set bit searching upward from `rr_ptr`, wrapping modulo N.
  - Register `grant`/`owner`, clear `count`, go to BURST.
  - If no `req` is set, stay in IDLE.
- BURST transfer condition: `xfer` = `req[owner]` & `fifo_space_available`.
  - `fifo_write_strobe` = `xfer`.
  - `ack[owner]` = `xfer`; all other `ack` bits are 0.
  - `fifo_write_data` = lane `owner`, always driven; it is don't-care when the strobe is low.
- On `xfer` with `last[owner]`: release the grant.
- On `xfer` with `count` == MAX_BURST-1 and no `last`: release the grant and pulse `forced_release`.
- On `xfer` otherwise: `count` += 1.
- `req[owner]` low in BURST (abort): release the grant with no transfer.
- `fifo_space_available` low with `req[owner]` high: stall; hold the grant, leave `count` unchanged, no strobe.
- Release actions:
  - Go to IDLE and clear `grant`.
  - Set `rr_ptr` = (`owner`+1) mod N.
  - `owner` keeps its value.
- `count` width: `CLOG2(MAX_BURST)`; it never wraps because release occurs at MAX_BURST-1.
- A requester must hold `data`/`last` stable while `req` is high and `ack` is low.
- Reset (asynchronous, any state including mid-burst):
  - State = IDLE, `grant` = 0, `owner` = 0, `rr_ptr` = 0, `count` = 0, `forced_release` = 0.
  - `ack` and the strobe fall to 0 immediately.
  - A partially written packet stays in the fifo; discarding it is the consumer's concern.

## Timing
- Arbitration latency: `req` rising in cycle t gives `grant` in cycle t+1; the first strobe is possible in t+1.
- Throughput: one word per cycle within a burst.
- Every release is followed by one IDLE cycle, so there is a 1-cycle bubble between bursts.
- Back-to-back packets from the same requester are allowed only when no other requester is pending; it then re-wins after the idle cycle.
- `forced_release` is registered and high in the IDLE cycle after the cut.
- The fifo's `space_available` is derived from its pointers, so a combinational strobe gated by it cannot overflow.
- Combinational paths: `fifo_space_available` → `fifo_write_strobe`/`ack`, and `req` → `fifo_write_strobe`/`ack`.

## Structure
- Shared package/header (next to `CLOG2`):
  - State encoding constants ARB_IDLE = 0, ARB_BURST = 1.
  - Default N / WIDTH / MAX_BURST values.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N]` and `ptr[ID_BITS]`.
  - Outputs: one-hot `pick` and index `pick_id`, implemented by rotate, find-first, rotate back.
- The rest (state register, counter, muxes) stays in the top module.

## Test plan
- Single requester: N=4, `req[2]` with a 3-word packet 0xA1,0xA2,0xA3 (`last` on the third word), space always high.
  - `grant` = 4'b0100 one cycle after `req`.
  - Three consecutive strobes writing A1,A2,A3.
  - Then IDLE, `rr_ptr` = 3.
- Fairness: all four `req` held high, 1-word packets each.
  - Grant order 0,1,2,3,0 with one idle cycle between grants.
- Forced release: MAX_BURST=4, `req[1]` streams 10 words with no `last`.
  - Strobes in groups of 4.
  - `forced_release` pulses after words 4 and 8.
  - `req[3]` pending is granted between the two groups.
- Backpressure: `fifo_space_available` low for 5 cycles mid-burst.
  - No strobe and no `ack` during those cycles; `grant` held; `count` unchanged.
  - Data resumes unchanged.
- Abort and reset: `req[0]` drops mid-burst.
  - IDLE next cycle, `rr_ptr` = 1.
  - Separately, `reset_n` low mid-burst clears `grant`/`ack`/strobe in the same cycle, with no clock edge needed.
- Integration: arbiter driving a `fifo` with NUM=8 and no reads, 3 requesters streaming.
  - Exactly 7 words written; `space_available` stops further writes.
  - `werror` stays 0.
